// File: rtl/freq_meter_pkg.sv
// Shared types and width helpers for the freq_meter period measurement block.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } fm_state_e;

  // Accumulator must hold the sum of 2**avg_log2 periods of up to cnt_width bits each.
  function automatic int fm_acc_width(input int cnt_width, input int avg_log2);
    return cnt_width + avg_log2;
  endfunction

endpackage

// File: rtl/sync_rise_det.sv
// Multi-flop synchronizer for an asynchronous input followed by a registered
// rising-edge pulse. Latency from a sig_i edge to rise_o is STAGES+1 cycles.
module sync_rise_det #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              sync_dly_q;
  logic              rise_q;

  // Shift sig_i through the synchronizer, then compare against the delayed copy.
  // NOTE: non-blocking assignments make every flop sample the pre-edge value of its neighbour.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      sync_dly_q <= 1'b0;
      rise_q     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[STAGES-2:0], sig_i};
      sync_dly_q <= sync_q[STAGES-1];
      rise_q     <= sync_q[STAGES-1] & ~sync_dly_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/freq_meter.sv
// Measures the period of an asynchronous signal in clk_i cycles, averaged over
// 2**AVG_LOG2 consecutive periods. Windows run back-to-back while enable is high.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int CNT_WIDTH   = 16,
  parameter int AVG_LOG2    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  input  logic                 sig_i,
  input  logic                 enable,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic                 valid_o,
  output logic                 timeout_o,
  output logic                 busy_o
);

  localparam int ACC_W = fm_acc_width(CNT_WIDTH, AVG_LOG2);
  localparam int EC_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [EC_W-1:0] EC_LAST = EC_W'((1 << AVG_LOG2) - 1);

  fm_state_e            state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [EC_W-1:0]      edge_cnt_q, edge_cnt_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic                 valid_q, valid_d;
  logic                 timeout_q, timeout_d;

  logic                 rise;
  logic                 closing;
  logic [ACC_W:0]       acc_inc;
  logic [ACC_W:0]       avg_full;
  logic [CNT_WIDTH-1:0] avg_sat;

  sync_rise_det #(
    .STAGES (SYNC_STAGES)
  ) u_sync_rise_det (
    .clk_i  (clk_i),
    .rst_n  (rst_n),
    .sig_i  (sig_i),
    .rise_o (rise)
  );

  // Window total including the closing cycle, computed one bit wider so a
  // closing edge on an all-ones accumulator does not wrap; saturate on overflow.
  assign acc_inc  = {1'b0, acc_q} + (ACC_W+1)'(1);
  assign avg_full = acc_inc >> AVG_LOG2;
  assign avg_sat  = (|avg_full[ACC_W:CNT_WIDTH]) ? '1 : avg_full[CNT_WIDTH-1:0];
  assign closing  = rise && (edge_cnt_q == EC_LAST);

  // Next-state and datapath control; closing edge outranks timeout, enable=0 forces IDLE.
  // NOTE: every target gets a default first so no path leaves a variable unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    edge_cnt_d = edge_cnt_q;
    period_d   = period_q;
    valid_d    = 1'b0;
    timeout_d  = timeout_q;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d   = ARM;
          timeout_d = 1'b0;
        end
      end
      ARM: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (rise) begin
          acc_d      = '0;
          edge_cnt_d = '0;
          state_d    = MEASURE;
        end
      end
      MEASURE: begin
        acc_d = acc_q + ACC_W'(1);
        if (closing) begin
          period_d   = avg_sat;
          valid_d    = 1'b1;
          acc_d      = '0;
          edge_cnt_d = '0;
          timeout_d  = 1'b0;
        end else begin
          if (rise) edge_cnt_d = edge_cnt_q + EC_W'(1);
          if (&acc_q) begin
            timeout_d = 1'b1;
            state_d   = ARM;
          end
        end
        if (!enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, accumulator and output registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      edge_cnt_q <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      edge_cnt_q <= edge_cnt_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
    end
  end

  assign period_o  = period_q;
  assign valid_o   = valid_q;
  assign timeout_o = timeout_q;
  assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: stimulus pushes the averaged period of each
// window it generates; an independent monitor pops on every valid_o pulse.
module tb_freq_meter;

  localparam int CW = 8;
  localparam int AL = 2;

  logic          clk_i = 1'b0;
  logic          rst_n;
  logic          sig_i;
  logic          enable;
  logic [CW-1:0] period_o;
  logic          valid_o;
  logic          timeout_o;
  logic          busy_o;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int cyc = 0;
  int last_vcyc = -1;
  int last_gap = 0;
  logic prev_valid = 1'b0;

  freq_meter #(
    .CNT_WIDTH   (CW),
    .AVG_LOG2    (AL),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .sig_i     (sig_i),
    .enable    (enable),
    .period_o  (period_o),
    .valid_o   (valid_o),
    .timeout_o (timeout_o),
    .busy_o    (busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare each published period with the oldest expected value.
  initial begin
    int e;
    forever begin
      @(posedge clk_i);
      #1;
      if (rst_n) begin
        if (valid_o && prev_valid) check("valid_back_to_back", 1, 0);
        if (valid_o) begin
          if (exp_q.size() == 0) begin
            check("unexpected_valid", int'(period_o), -1);
          end else begin
            e = exp_q.pop_front();
            check("period", int'(period_o), e);
          end
          if (last_vcyc >= 0) last_gap = cyc - last_vcyc;
          last_vcyc = cyc;
        end
      end
      prev_valid = valid_o;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // High and low time of period k of a window for a given stimulus pattern.
  task automatic pick(input int mode, input int k, output int h, output int l);
    case (mode)
      0:       begin h = $urandom_range(2, 60); l = $urandom_range(2, 60); end
      1:       begin h = 5; l = 5; end
      2:       begin h = 5; l = (k % 2 == 1) ? 6 : 5; end
      3:       begin h = 4; l = 4; end
      4:       begin h = 2; l = 2; end
      default: begin h = 5; l = 5; end
    endcase
  endtask

  // Arming rise, then n_win windows of four periods, then the final closing rise.
  task automatic run_segment(input int mode, input int n_win);
    int h, l, sum;
    for (int w = 0; w < n_win; w++) begin
      sum = 0;
      for (int k = 0; k < 4; k++) begin
        pick(mode, k, h, l);
        sum += h + l;
        sig_i = 1'b1;
        repeat (h) @(negedge clk_i);
        sig_i = 1'b0;
        repeat (l) @(negedge clk_i);
      end
      exp_q.push_back(sum / (1 << AL));
    end
    sig_i = 1'b1;
    repeat (8) @(negedge clk_i);
  endtask

  task automatic arm_start();
    @(negedge clk_i);
    sig_i  = 1'b0;
    enable = 1'b1;
    repeat (4) @(negedge clk_i);
  endtask

  task automatic stop();
    @(negedge clk_i);
    enable = 1'b0;
    sig_i  = 1'b0;
    repeat (6) @(negedge clk_i);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk_i);
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int saved;
    bit seen;

    // Reset held while sig_i toggles: every output must stay at zero.
    rst_n  = 1'b0;
    enable = 1'b1;
    sig_i  = 1'b0;
    repeat (12) begin
      @(negedge clk_i);
      check("reset_outputs", int'({period_o, valid_o, timeout_o, busy_o}), 0);
      sig_i = ~sig_i;
    end
    @(negedge clk_i);
    enable = 1'b0;
    sig_i  = 1'b0;
    rst_n  = 1'b1;
    repeat (3) @(negedge clk_i);
    check("idle_after_reset_busy", int'(busy_o), 0);

    // Steady period 10: result 10 every 40 cycles.
    last_vcyc = -1;
    arm_start();
    check("arm_busy", int'(busy_o), 1);
    run_segment(1, 3);
    drain("drain_p10");
    check("gap_p10", last_gap, 40);
    stop();
    check("stop_busy", int'(busy_o), 0);
    check("period_held_after_stop", int'(period_o), 10);

    // Alternating 10/11: sum 42 truncates to 10.
    arm_start();
    run_segment(2, 2);
    drain("drain_alt");
    stop();

    // Minimum legal period 4: result 4 every 16 cycles.
    last_vcyc = -1;
    arm_start();
    run_segment(4, 2);
    drain("drain_p4");
    check("gap_p4", last_gap, 16);
    stop();

    // Random periods.
    repeat (6) begin
      arm_start();
      run_segment(0, $urandom_range(1, 3));
      drain("drain_rand");
      stop();
    end

    // Abort partway into a window: no result, period held, idle next cycle.
    saved = int'(period_o);
    arm_start();
    sig_i = 1'b1;
    repeat (3) @(negedge clk_i);
    sig_i = 1'b0;
    repeat (12) @(negedge clk_i);
    enable = 1'b0;
    @(posedge clk_i);
    #1;
    check("abort_busy", int'(busy_o), 0);
    repeat (40) @(negedge clk_i);
    check("abort_period_held", int'(period_o), saved);
    arm_start();
    run_segment(3, 1);
    drain("drain_after_abort");
    stop();

    // Stuck input after arming: timeout, no result, then recovery at period 8.
    saved = int'(period_o);
    arm_start();
    sig_i = 1'b1;
    repeat (3) @(negedge clk_i);
    sig_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk_i);
      if (timeout_o) begin
        seen = 1'b1;
        break;
      end
    end
    check("timeout_set", int'(seen), 1);
    check("timeout_rearm_busy", int'(busy_o), 1);
    check("timeout_period_held", int'(period_o), saved);
    run_segment(3, 2);
    drain("drain_after_timeout");
    check("timeout_cleared", int'(timeout_o), 0);
    stop();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
